// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file address width and the index of the zero register (XZR).
package cpu_pkg;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XZR_IDX    = 31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/decoder_nx2n.sv
// Combinational N-to-2^N one-hot decoder; all-zero output when enable is low.
module decoder_nx2n #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic                  enable,
    input  logic [ADDR_W-1:0]     addr,
    output logic [(1<<ADDR_W)-1:0] dec
);
    always_comb begin
        dec = '0;
        if (enable)
            dec[addr] = 1'b1;
    end
endmodule

// File: rtl/decoder_pipe.sv
// Registered one-hot write-enable decoder with zero-register suppression and a
// 1-entry skid buffer so back-pressure never drops or duplicates a transaction.
module decoder_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W    = REG_ADDR_W,
    parameter bit          MASK_ZERO = 1'b1,
    parameter int unsigned ZERO_IDX  = XZR_IDX
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic                    in_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [(1<<ADDR_W)-1:0]  out_decode,
    output logic [ADDR_W-1:0]       out_addr,
    output logic                    out_hit
);
    localparam int unsigned DEC_W = 1 << ADDR_W;

    logic              masked;
    logic              dec_en;
    logic [DEC_W-1:0]  in_dec;
    logic              in_xfer;
    logic              out_load;

    logic              skid_valid;
    logic [DEC_W-1:0]  skid_decode;
    logic [ADDR_W-1:0] skid_addr;

    assign masked   = MASK_ZERO && (in_addr == ADDR_W'(ZERO_IDX));
    assign dec_en   = in_en && !masked;
    assign in_ready = !skid_valid;
    assign in_xfer  = in_valid && in_ready;
    assign out_load = !out_valid || out_ready;

    decoder_nx2n #(.ADDR_W(ADDR_W)) u_dec (
        .enable (dec_en),
        .addr   (in_addr),
        .dec    (in_dec)
    );

    // The skid can only be occupied while the output is stalled, so when it is
    // full in_ready is low and a skid unload never coincides with an input transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_decode  <= '0;
            out_addr    <= '0;
            out_hit     <= 1'b0;
            skid_valid  <= 1'b0;
            skid_decode <= '0;
            skid_addr   <= '0;
        end else if (out_load) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_decode <= skid_decode;
                out_addr   <= skid_addr;
                out_hit    <= |skid_decode;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                out_valid  <= 1'b1;
                out_decode <= in_dec;
                out_addr   <= in_addr;
                out_hit    <= |in_dec;
            end else begin
                out_valid <= 1'b0;
                out_hit   <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid  <= 1'b1;
            skid_decode <= in_dec;
            skid_addr   <= in_addr;
        end
    end
endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: three widths (5 masked, 3 unmasked, 1 masked at index 1)
// driven by one handshake stream and checked against a capacity-2 FIFO model.
module tb_decoder_pipe;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_en, out_ready;
    logic [4:0]  a5;

    logic        d5_ir, d5_ov, d5_oh;
    logic [31:0] d5_od;
    logic [4:0]  d5_oa;
    logic        d3_ir, d3_ov, d3_oh;
    logic [7:0]  d3_od;
    logic [2:0]  d3_oa;
    logic        d1_ir, d1_ov, d1_oh;
    logic [1:0]  d1_od;
    logic [0:0]  d1_oa;

    int n_chk = 0;
    int n_pass = 0;
    logic [5:0] q[$];   // {en, addr} of accepted, not yet delivered transactions

    always #5 clk = ~clk;

    decoder_pipe #(.ADDR_W(5), .MASK_ZERO(1'b1), .ZERO_IDX(31)) d5 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d5_ir),
        .in_addr(a5), .in_en(in_en), .out_valid(d5_ov), .out_ready(out_ready),
        .out_decode(d5_od), .out_addr(d5_oa), .out_hit(d5_oh));

    decoder_pipe #(.ADDR_W(3), .MASK_ZERO(1'b0), .ZERO_IDX(0)) d3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d3_ir),
        .in_addr(a5[2:0]), .in_en(in_en), .out_valid(d3_ov), .out_ready(out_ready),
        .out_decode(d3_od), .out_addr(d3_oa), .out_hit(d3_oh));

    decoder_pipe #(.ADDR_W(1), .MASK_ZERO(1'b1), .ZERO_IDX(1)) d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d1_ir),
        .in_addr(a5[0:0]), .in_en(in_en), .out_valid(d1_ov), .out_ready(out_ready),
        .out_decode(d1_od), .out_addr(d1_oa), .out_hit(d1_oh));

    function automatic logic [31:0] ref_dec(int w, bit mz, int zi, logic [4:0] a, bit e);
        int idx;
        idx = int'(a) % (1 << w);
        if (!e || (mz && idx == zi))
            return 32'd0;
        return 32'd1 << idx;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic check_all();
        logic [5:0]  f;
        logic [31:0] e5, e3, e1;
        chk("d5.out_valid", 32'(d5_ov), 32'(q.size() > 0));
        chk("d3.out_valid", 32'(d3_ov), 32'(q.size() > 0));
        chk("d1.out_valid", 32'(d1_ov), 32'(q.size() > 0));
        chk("d5.in_ready", 32'(d5_ir), 32'(q.size() < 2));
        chk("d3.in_ready", 32'(d3_ir), 32'(q.size() < 2));
        chk("d1.in_ready", 32'(d1_ir), 32'(q.size() < 2));
        if (q.size() > 0) begin
            f  = q[0];
            e5 = ref_dec(5, 1'b1, 31, f[4:0], f[5]);
            e3 = ref_dec(3, 1'b0, 0, f[4:0], f[5]);
            e1 = ref_dec(1, 1'b1, 1, f[4:0], f[5]);
            chk("d5.out_addr", 32'(d5_oa), 32'(f[4:0]));
            chk("d3.out_addr", 32'(d3_oa), 32'(f[2:0]));
            chk("d1.out_addr", 32'(d1_oa), 32'(f[0]));
            chk("d5.out_decode", d5_od, e5);
            chk("d3.out_decode", 32'(d3_od), e3);
            chk("d1.out_decode", 32'(d1_od), e1);
            chk("d5.out_hit", 32'(d5_oh), 32'(e5 != 0));
            chk("d3.out_hit", 32'(d3_oh), 32'(e3 != 0));
            chk("d1.out_hit", 32'(d1_oh), 32'(e1 != 0));
        end else begin
            chk("d5.out_hit_idle", 32'(d5_oh), 32'd0);
            chk("d3.out_hit_idle", 32'(d3_oh), 32'd0);
            chk("d1.out_hit_idle", 32'(d1_oh), 32'd0);
        end
    endtask

    // Drive one cycle of inputs (from the falling edge), advance the model at the
    // rising edge, then check every DUT at the next falling edge.
    task automatic step(input bit v, input logic [4:0] a, input bit e, input bit ordy, input bit rst);
        bit ixfer, oxfer;
        in_valid  = v;
        a5        = a;
        in_en     = e;
        out_ready = ordy;
        reset     = rst;
        ixfer = v && (q.size() < 2);
        oxfer = (q.size() > 0) && ordy;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (oxfer)
                void'(q.pop_front());
            if (ixfer)
                q.push_back({e, a});
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lit3 [8];
        lit3 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        in_valid = 1'b0; in_en = 1'b0; out_ready = 1'b0; a5 = '0; reset = 1'b1;
        @(negedge clk);

        // reset with a live transfer presented
        step(1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
        step(1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
        chk("t1.out_decode", d5_od, 32'd0);
        chk("t1.in_ready", 32'(d5_ir), 32'd1);

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 5'(i), 1'b1, 1'b1, 1'b0);
            chk("t2.decode3", 32'(d3_od), 32'(lit3[i]));
        end
        step(1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        chk("t2.en0_decode", 32'(d3_od), 32'd0);
        chk("t2.en0_hit", 32'(d3_oh), 32'd0);

        step(1'b1, 5'd31, 1'b1, 1'b1, 1'b0);
        chk("t3.xzr_decode", d5_od, 32'd0);
        chk("t3.xzr_hit", 32'(d5_oh), 32'd0);
        chk("t3.xzr_addr", 32'(d5_oa), 32'd31);
        step(1'b1, 5'd30, 1'b1, 1'b1, 1'b0);
        chk("t3.a30_decode", d5_od, 32'h4000_0000);
        chk("t3.a30_hit", 32'(d5_oh), 32'd1);
        step(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);

        step(1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("t4.hold4", d5_od, 32'h0000_0010);
        chk("t4.full_ready", 32'(d5_ir), 32'd0);
        step(1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        chk("t4.stall4", d5_od, 32'h0000_0010);
        step(1'b1, 5'd12, 1'b1, 1'b1, 1'b0);
        chk("t4.second9", d5_od, 32'h0000_0200);
        step(1'b1, 5'd12, 1'b1, 1'b1, 1'b0);
        chk("t4.third12", d5_od, 32'h0000_1000);
        step(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("t4.drained", 32'(d5_ov), 32'd0);

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 5'(i + 8), 1'b1, 1'b1, 1'b0);
            chk("t5.valid", 32'(d5_ov), 32'd1);
            chk("t5.addr", 32'(d5_oa), 32'(i + 8));
        end
        step(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);

        step(1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("t6.valid", 32'(d5_ov), 32'd0);
        chk("t6.ready", 32'(d5_ir), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            chk("t6.no_ghost", 32'(d5_ov), 32'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom), $urandom_range(0, 5) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
